// File: rtl/aes_result_queue.sv
// rtl/aes_result_queue.sv - in-order AES32 result queue between execute stage and XIF result interface
// Optional feature: define AES_RESQ_BYPASS_EN for zero-latency pass-through on an empty queue.
module aes_result_queue #(
  parameter int DEPTH       = 4,
  parameter int X_ID_WIDTH  = 4,
  parameter int X_RFW_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_valid_i,
  output logic                   push_ready_o,
  input  logic [X_ID_WIDTH-1:0]  push_id_i,
  input  logic [4:0]             push_rd_i,
  input  logic [X_RFW_WIDTH-1:0] push_data_i,
  input  logic                   commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]  commit_id_i,
  input  logic                   commit_kill_i,
  output logic                   result_valid_o,
  input  logic                   result_ready_i,
  output logic [X_ID_WIDTH-1:0]  result_id_o,
  output logic [4:0]             result_rd_o,
  output logic [X_RFW_WIDTH-1:0] result_data_o,
  output logic                   result_we_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   err_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    HEAD_WAIT,
    HEAD_DROP,
    HEAD_EMIT
  } head_e;

  logic [DEPTH-1:0]       vld;
  logic [DEPTH-1:0]       cmt;
  logic [DEPTH-1:0]       kill;
  logic [X_ID_WIDTH-1:0]  id_q   [DEPTH];
  logic [4:0]             rd_q   [DEPTH];
  logic [X_RFW_WIDTH-1:0] data_q [DEPTH];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [CW-1:0]          count;
  logic                   err;

  head_e                  head;
  logic [DEPTH-1:0]       cam_hit;
  logic                   push_fire;
  logic                   push_hit;
  logic                   commit_err;
  logic                   bypass_kill;
  logic                   bypass_emit;
  logic                   store;
  logic                   pop;

  assign push_ready_o = (count != FULL);
  assign push_fire    = push_valid_i & push_ready_o;
  // A commit in the same cycle as the push of its id targets the incoming entry.
  assign push_hit     = push_fire & commit_valid_i & (push_id_i == commit_id_i);
  assign commit_err   = commit_valid_i & ~push_hit & ~(|cam_hit);

`ifdef AES_RESQ_BYPASS_EN
  logic bypass_cand;
  assign bypass_cand = (count == '0) & push_hit;
  assign bypass_kill = bypass_cand & commit_kill_i;
  assign bypass_emit = bypass_cand & ~commit_kill_i & result_ready_i;
`else
  assign bypass_kill = 1'b0;
  assign bypass_emit = 1'b0;
`endif

  assign store = push_fire & ~bypass_kill & ~bypass_emit;
  assign pop   = (head == HEAD_DROP) | ((head == HEAD_EMIT) & result_ready_i);

  // Search valid, not-yet-committed entries for the committing id.
  always_comb begin
    cam_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cam_hit[i] = vld[i] & ~cmt[i] & (id_q[i] == commit_id_i);
    end
  end

  // Classify the head entry: wait for commit, drop a killed one, or emit.
  always_comb begin
    head = HEAD_WAIT;
    if (vld[rd_ptr] && cmt[rd_ptr]) begin
      head = kill[rd_ptr] ? HEAD_DROP : HEAD_EMIT;
    end
  end

  // Drive the XIF result from the head entry (or the bypassed push); zero when idle.
  always_comb begin
    result_valid_o = 1'b0;
    result_id_o    = '0;
    result_rd_o    = '0;
    result_data_o  = '0;
    if (head == HEAD_EMIT) begin
      result_valid_o = 1'b1;
      result_id_o    = id_q[rd_ptr];
      result_rd_o    = rd_q[rd_ptr];
      result_data_o  = data_q[rd_ptr];
    end else if (bypass_emit) begin
      result_valid_o = 1'b1;
      result_id_o    = push_id_i;
      result_rd_o    = push_rd_i;
      result_data_o  = push_data_i;
    end
  end

  assign result_we_o = result_valid_o;
  assign count_o     = count;
  assign err_o       = err;

  // Queue storage, pointers, occupancy and the sticky protocol error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld    <= '0;
      cmt    <= '0;
      kill   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        id_q[i]   <= '0;
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      // The CAM only hits uncommitted entries, so it never touches the popped head.
      if (commit_valid_i && !push_hit) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (cam_hit[i]) begin
            cmt[i]  <= 1'b1;
            kill[i] <= commit_kill_i;
          end
        end
      end
      // Pop and store slots only coincide when empty or full, where one side is idle.
      if (pop) begin
        vld[rd_ptr]  <= 1'b0;
        cmt[rd_ptr]  <= 1'b0;
        kill[rd_ptr] <= 1'b0;
        rd_ptr       <= rd_ptr + PW'(1);
      end
      if (store) begin
        vld[wr_ptr]    <= 1'b1;
        cmt[wr_ptr]    <= push_hit;
        kill[wr_ptr]   <= push_hit & commit_kill_i;
        id_q[wr_ptr]   <= push_id_i;
        rd_q[wr_ptr]   <= push_rd_i;
        data_q[wr_ptr] <= push_data_i;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      count <= count + CW'(store) - CW'(pop);
      if (commit_err) begin
        err <= 1'b1;
      end
    end
  end

endmodule
